if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the next-PC block in the MIPS datapath.
- Holds the architectural PC register and fetches the instruction at PC over a request/grant/response instruction-memory port.
- Presents the instruction to decode with a valid/ready handshake.
- Loads the next-PC value into PC when decode accepts an instruction; a retired-fetch counter and a misalignment trap are included.

---
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/if_fetch_unit.sv | 97 +++++++++
 tb/tb_if_fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Bundles the instruction-memory port, the decode handshake and the status outputs of the fetch stage.
// The master modport belongs to the fetch unit, and the slave modport belongs to its environment.
interface if_fetch_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      npc;
  logic [31:0]      pc;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic [31:0]      inst;
  logic             inst_valid;
  logic             inst_ready;
  logic             fetch_err;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    input  npc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output pc, imem_req, imem_addr, inst, inst_valid, fetch_err, fetch_cnt
  );

  modport slave (
    output npc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  pc, imem_req, imem_addr, inst, inst_valid, fetch_err, fetch_cnt
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: it owns the PC, fetches over a req/gnt/rvalid port, and hands instructions to decode.
// A misaligned next PC traps into a sticky error state, and only reset leaves that state.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input logic             clk,
  input logic             rstn,
  if_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic             r_inst_valid;
  logic             r_fetch_err;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_imem_req;

  assign w_imem_req = (r_state == S_REQ);

  // Fetch FSM with PC, instruction, trap and retired-count registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= 32'h0000_0000;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_fetch_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_gnt) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_inst       <= bus.imem_rdata;
            r_inst_valid <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            r_inst_valid <= 1'b0;
            r_pc         <= bus.npc;
            r_fetch_cnt  <= r_fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            // The faulting npc remains in pc so that the trap handler can report it
            if (bus.npc[1:0] == 2'b00) begin
              r_state <= S_REQ;
            end else begin
              r_state     <= S_ERR;
              r_fetch_err <= 1'b1;
            end
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_ERR: begin
          r_state      <= S_ERR;
          r_fetch_err  <= 1'b1;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.imem_req   = w_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_inst_valid;
  assign bus.fetch_err  = r_fetch_err;
  assign bus.fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. The expected values are worked out by hand from the fetch protocol.
module tb_if_fetch_unit;

  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;

  if_fetch_unit_if #(.CNT_W(32)) bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstn = 1'b0;
    bus.npc = 32'h0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0;

    // Reset state
    step();
    check("rst_pc", bus.pc, 32'h0000_3000);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_valid", bus.inst_valid, 1'b0);
    check("rst_err", bus.fetch_err, 1'b0);
    check("rst_cnt", bus.fetch_cnt, 32'h0);

    // Fetch at full speed
    rstn = 1'b1; bus.imem_gnt = 1'b1; bus.npc = 32'h0000_3004;
    bus.inst_ready = 1'b1; bus.imem_rdata = 32'h2008_0005;
    step();
    check("t1_req", bus.imem_req, 1'b1);
    check("t1_addr", bus.imem_addr, 32'h0000_3000);
    step();
    check("t1_wait_req", bus.imem_req, 1'b0);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1;
    step();
    check("t1_valid", bus.inst_valid, 1'b1);
    check("t1_inst", bus.inst, 32'h2008_0005);
    bus.imem_rvalid = 1'b0;
    step();
    check("t1_pc", bus.pc, 32'h0000_3004);
    check("t1_req2", bus.imem_req, 1'b1);
    check("t1_addr2", bus.imem_addr, 32'h0000_3004);
    check("t1_cnt", bus.fetch_cnt, 32'd1);
    check("t1_valid_clr", bus.inst_valid, 1'b0);

    // The grant is withheld for 4 cycles
    rstn = 1'b0; bus.inst_ready = 1'b0;
    step();
    rstn = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("t2_req", bus.imem_req, 1'b1);
      check("t2_addr", bus.imem_addr, 32'h0000_3000);
      step();
    end
    check("t2_req_last", bus.imem_req, 1'b1);
    check("t2_addr_last", bus.imem_addr, 32'h0000_3000);
    bus.imem_gnt = 1'b1;
    step();
    check("t2_wait", bus.imem_req, 1'b0);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h8C09_0000;
    step();
    check("t2_inst", bus.inst, 32'h8C09_0000);

    // Back-pressure while npc toggles; a stray rvalid during the stall must be ignored
    bus.imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      bus.npc = (i % 2 == 1) ? 32'h0000_4000 : 32'h0000_3008;
      step();
      check("t3_inst", bus.inst, 32'h8C09_0000);
      check("t3_pc", bus.pc, 32'h0000_3000);
      check("t3_valid", bus.inst_valid, 1'b1);
    end
    bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1; bus.npc = 32'h0000_3008;
    step();
    check("t3_pc_take", bus.pc, 32'h0000_3008);
    check("t3_cnt", bus.fetch_cnt, 32'd1);
    check("t3_req", bus.imem_req, 1'b1);
    bus.inst_ready = 1'b0;

    // A misaligned npc traps
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0020;
    step();
    bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1; bus.npc = 32'h0000_3006;
    step();
    check("t4_pc", bus.pc, 32'h0000_3006);
    check("t4_err", bus.fetch_err, 1'b1);
    check("t4_cnt", bus.fetch_cnt, 32'd2);
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1; bus.npc = 32'h0000_3010;
    for (int i = 0; i < 3; i++) begin
      check("t4_req", bus.imem_req, 1'b0);
      check("t4_valid", bus.inst_valid, 1'b0);
      check("t4_err_sticky", bus.fetch_err, 1'b1);
      check("t4_pc_hold", bus.pc, 32'h0000_3006);
      step();
    end
    rstn = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0;
    step();
    check("t4_err_clr", bus.fetch_err, 1'b0);
    check("t4_pc_rst", bus.pc, 32'h0000_3000);

    // Reset during WAIT, followed by a stale response
    rstn = 1'b1; bus.imem_gnt = 1'b1;
    step();
    step();
    check("t5_in_wait", bus.imem_req, 1'b0);
    rstn = 1'b0; bus.imem_gnt = 1'b0;
    step();
    rstn = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    check("t5_valid", bus.inst_valid, 1'b0);
    check("t5_inst", bus.inst, 32'h0);
    check("t5_req", bus.imem_req, 1'b1);
    check("t5_addr", bus.imem_addr, 32'h0000_3000);
    step();
    check("t5_valid2", bus.inst_valid, 1'b0);
    check("t5_req2", bus.imem_req, 1'b1);
    bus.imem_rvalid = 1'b0;

    // The retired-fetch counter wraps to zero
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_2222;
    step();
    bus.imem_rvalid = 1'b0;
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    step();
    release dut.r_fetch_cnt;
    check("t6_preload", bus.fetch_cnt, 32'hFFFF_FFFF);
    bus.inst_ready = 1'b1; bus.npc = 32'h0000_300C;
    step();
    check("t6_wrap", bus.fetch_cnt, 32'h0);
    check("t6_pc", bus.pc, 32'h0000_300C);
    check("t6_err", bus.fetch_err, 1'b0);
    check("t6_req", bus.imem_req, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
